// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared types and constants for the program loader.
//   state_e          FSM state encoding (CHECK only exists with LOADER_CHECKSUM_EN)
//   INSTRUCTION_SIZE instruction word width
//   BYTE_WIDTH       stream byte width
//   BYTES_PER_WORD   stream bytes assembled into one instruction word
// Build option: LOADER_CHECKSUM_EN adds the CHECK state.
package program_loader_pkg;

   localparam int INSTRUCTION_SIZE = 24;
   localparam int BYTE_WIDTH       = 8;
   localparam int BYTES_PER_WORD   = INSTRUCTION_SIZE / BYTE_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK = 3'd3,
`endif
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port.
//   s_valid/s_ready/s_data     byte stream, transfer on s_valid && s_ready
//   imem_we/imem_addr/imem_wdata instruction-memory write port
// Modports: slave = loader side, master = stream source / memory side.
interface program_loader_if #(
   parameter int IW = 24,
   parameter int BW = 8,
   parameter int AW = 16
) ();
   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] s_data;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;

   modport slave  (input  s_valid, s_data,
                   output s_ready, imem_we, imem_addr, imem_wdata);
   modport master (output s_valid, s_data,
                   input  s_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/loader_byte_packer.sv
// loader_byte_packer: shifts stream bytes MSB-first into an instruction word.
//   clk, rst       clock, synchronous active-high reset
//   clear_i        restart byte counting (new load)
//   shift_i        accept byte_i this cycle
//   byte_i         stream byte
//   word_o         assembled word (registered)
//   word_valid_o   high in the cycle the last byte of a word is shifted in
module loader_byte_packer #(
   parameter int IW = 24,
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          shift_i,
   input  logic [BW-1:0] byte_i,
   output logic [IW-1:0] word_o,
   output logic          word_valid_o
);
   localparam int NB    = IW / BW;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

   logic [IW-1:0]    word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;

   assign last = (cnt_q == CNT_W'(NB - 1));

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         word_d = {word_q[IW-BW-1:0], byte_i};
         cnt_d  = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = shift_i && !clear_i && last;
endmodule

// File: rtl/program_loader.sv
// program_loader: loads word_count instructions from a byte stream into
// instruction memory while holding the processor in reset.
//   clk, rst     clock, synchronous active-high reset
//   start        pulse that begins a load (ignored while busy)
//   word_count   instructions to load, sampled on accepted start
//   bus          program_loader_if.slave (byte stream + imem write port)
//   cpu_rst      processor reset hold, released only in DONE
//   busy, done, chk_err  status
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | accepting stream bytes of the current word
// WRITE | one-cycle imem write of the assembled word
// CHECK | accepting checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load finished, processor released, waiting for start
module program_loader
   import program_loader_pkg::*;
#(
   parameter int instructionSize = INSTRUCTION_SIZE,
   parameter int byteWidth       = BYTE_WIDTH,
   parameter int addrSize        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [addrSize-1:0] word_count,
   program_loader_if.slave     bus,
   output logic                cpu_rst,
   output logic                busy,
   output logic                done,
   output logic                chk_err
);
   state_e                 state_q;
   logic [addrSize-1:0]    count_q;
   logic [addrSize-1:0]    addr_q;
   logic [addrSize-1:0]    addr_next;
   logic                   s_ready_q, imem_we_q, busy_q, done_q, cpu_rst_q;
   logic                   xfer, accept_start, word_valid;
   logic [instructionSize-1:0] word;
`ifdef LOADER_CHECKSUM_EN
   logic [byteWidth-1:0]   acc_q;
   logic                   chk_err_q;
`endif

   assign xfer         = bus.s_valid && s_ready_q;
   assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
   assign addr_next    = addr_q + 1'b1;

   // Checksum bytes also arrive via xfer, so only RECV feeds the packer.
   loader_byte_packer #(
      .IW (instructionSize),
      .BW (byteWidth)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (accept_start),
      .shift_i      (xfer && state_q == S_RECV),
      .byte_i       (bus.s_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         addr_q    <= '0;
         s_ready_q <= 1'b0;
         imem_we_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         acc_q     <= '0;
         chk_err_q <= 1'b0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  count_q   <= word_count;
                  addr_q    <= '0;
                  done_q    <= 1'b0;
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
                  s_ready_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  acc_q     <= '0;
                  chk_err_q <= 1'b0;
`endif
                  if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q   <= S_CHECK;
`else
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     cpu_rst_q <= 1'b0;
                     s_ready_q <= 1'b0;
`endif
                  end else begin
                     state_q <= S_RECV;
                  end
               end
            end
            S_RECV: begin
`ifdef LOADER_CHECKSUM_EN
               if (xfer) acc_q <= acc_q ^ bus.s_data;
`endif
               if (word_valid) begin
                  state_q   <= S_WRITE;
                  s_ready_q <= 1'b0;
                  imem_we_q <= 1'b1;
               end
            end
            S_WRITE: begin
               addr_q <= addr_next;
               if (addr_next == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q   <= S_CHECK;
                  s_ready_q <= 1'b1;
`else
                  state_q   <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b0;
`endif
               end else begin
                  state_q   <= S_RECV;
                  s_ready_q <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (xfer) begin
                  chk_err_q <= |(acc_q ^ bus.s_data);
                  state_q   <= S_DONE;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b0;
               end
            end
`endif
            default: begin
               state_q   <= S_IDLE;
               s_ready_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               cpu_rst_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.s_ready    = s_ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word;
   assign cpu_rst        = cpu_rst_q;
   assign busy           = busy_q;
   assign done           = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign chk_err        = chk_err_q;
`else
   assign chk_err        = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
// With LOADER_CHECKSUM_EN defined it also feeds and checks checksum bytes.
module tb_program_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] word_count;
   logic        cpu_rst, busy, done, chk_err;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] wr_addr[$];
   logic [23:0] wr_data[$];

   program_loader_if #(.IW(24), .BW(8), .AW(16)) bus ();

   program_loader #(
      .instructionSize (24),
      .byteWidth       (8),
      .addrSize        (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .chk_err    (chk_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr.push_back(bus.imem_addr);
         wr_data.push_back(bus.imem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic took;
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      n    = 0;
      took = 1'b0;
      while (!took && n < 20) begin
         @(posedge clk);
         took = bus.s_ready;
         n++;
      end
      #1;
      if (!took) begin
         n_assert++;
         n_fail++;
         $error("FAIL send_timeout: byte %0h not accepted, observed s_ready 0 expected 1", b);
      end
   endtask

   task automatic start_load(input logic [15:0] wc);
      start      = 1'b1;
      word_count = wc;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] w);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic check_write(input string tag, input logic [15:0] a, input logic [23:0] d);
      chk({tag, "_we"},    {31'd0, bus.imem_we}, 32'd1);
      chk({tag, "_addr"},  {16'd0, bus.imem_addr}, {16'd0, a});
      chk({tag, "_wdata"}, {8'd0, bus.imem_wdata}, {8'd0, d});
      chk({tag, "_ready"}, {31'd0, bus.s_ready}, 32'd0);
   endtask

   task automatic end_load(input logic [7:0] ck, input logic err);
`ifdef LOADER_CHECKSUM_EN
      send_byte(ck);
      bus.s_valid = 1'b0;
      chk("chk_err", {31'd0, chk_err}, {31'd0, err});
`else
      bus.s_valid = 1'b0;
      tick();
      chk("chk_err_off", {31'd0, chk_err}, 32'd0);
      if (ck == 8'h00 && err) n_assert = n_assert + 0;
`endif
      chk("done",    {31'd0, done},    32'd1);
      chk("busy",    {31'd0, busy},    32'd0);
      chk("cpu_rst", {31'd0, cpu_rst}, 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      word_count  = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      tick();
      tick();
      chk("rst_cpu_rst", {31'd0, cpu_rst},        32'd1);
      chk("rst_busy",    {31'd0, busy},           32'd0);
      chk("rst_done",    {31'd0, done},           32'd0);
      chk("rst_chk_err", {31'd0, chk_err},        32'd0);
      chk("rst_s_ready", {31'd0, bus.s_ready},    32'd0);
      chk("rst_we",      {31'd0, bus.imem_we},    32'd0);
      chk("rst_addr",    {16'd0, bus.imem_addr},  32'd0);
      chk("rst_wdata",   {8'd0, bus.imem_wdata},  32'd0);
      rst = 1'b0;
      tick();

      // Two words, continuous stream. Checksum of all six bytes is F9.
      start_load(16'd2);
      chk("ld1_busy",    {31'd0, busy},        32'd1);
      chk("ld1_ready",   {31'd0, bus.s_ready}, 32'd1);
      chk("ld1_cpu_rst", {31'd0, cpu_rst},     32'd1);
      send_word(24'h123456);
      check_write("ld1_w0", 16'd0, 24'h123456);
      send_word(24'hABCDEF);
      check_write("ld1_w1", 16'd1, 24'hABCDEF);
      end_load(8'hF9, 1'b0);
      chk("ld1_nwr",   wr_addr.size(), 32'd2);
      chk("ld1_addr1", {16'd0, wr_addr[1]}, 32'd1);
      chk("ld1_data0", {8'd0, wr_data[0]},  32'h123456);
      wr_addr.delete();
      wr_data.delete();

      // Stall between bytes 2 and 3, plus a start pulse that must be ignored.
      start_load(16'd2);
      send_byte(8'h12);
      send_byte(8'h34);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            start      = 1'b1;
            word_count = 16'd5;
         end
         tick();
         start = 1'b0;
         chk("stall_we",    {31'd0, bus.imem_we}, 32'd0);
         chk("stall_ready", {31'd0, bus.s_ready}, 32'd1);
      end
      send_byte(8'h56);
      check_write("ld2_w0", 16'd0, 24'h123456);
      send_word(24'hABCDEF);
      check_write("ld2_w1", 16'd1, 24'hABCDEF);
      end_load(8'hF9, 1'b0);
      chk("ld2_nwr", wr_addr.size(), 32'd2);
      wr_addr.delete();
      wr_data.delete();

      // Zero-length load.
      start_load(16'd0);
`ifdef LOADER_CHECKSUM_EN
      chk("zero_ready", {31'd0, bus.s_ready}, 32'd1);
`endif
      end_load(8'h00, 1'b0);
      tick();
      chk("zero_nwr", wr_addr.size(), 32'd0);

      // Reset after byte 5, then a fresh one-word load from address 0.
      start_load(16'd2);
      send_word(24'h123456);
      send_byte(8'hAB);
      send_byte(8'hCD);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_we",      {31'd0, bus.imem_we},   32'd0);
      chk("abort_cpu_rst", {31'd0, cpu_rst},       32'd1);
      chk("abort_done",    {31'd0, done},          32'd0);
      chk("abort_busy",    {31'd0, busy},          32'd0);
      chk("abort_ready",   {31'd0, bus.s_ready},   32'd0);
      chk("abort_addr",    {16'd0, bus.imem_addr}, 32'd0);
      tick();
      chk("abort_we2", {31'd0, bus.imem_we}, 32'd0);
      chk("abort_nwr", wr_addr.size(), 32'd1);
      chk("abort_a0",  {16'd0, wr_addr[0]}, 32'd0);
      wr_addr.delete();
      wr_data.delete();
      start_load(16'd1);
      send_word(24'h112233);
      check_write("reload_w0", 16'd0, 24'h112233);
      end_load(8'h00, 1'b0);
      chk("reload_nwr", wr_addr.size(), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      // 01^02^04 = 07: matching checksum clears chk_err, 06 sets it.
      start_load(16'd1);
      send_word(24'h010204);
      check_write("ck_ok_w0", 16'd0, 24'h010204);
      end_load(8'h07, 1'b0);
      start_load(16'd1);
      chk("ck_clear", {31'd0, chk_err}, 32'd0);
      send_word(24'h010204);
      end_load(8'h06, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameters: instructionSize, default 24, instruction word width; byteWidth, default 8, stream byte width; addrSize, default 16, instruction-memory address width.
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: start  input  1  one-cycle pulse that begins a load.
REQ-005 SHALL have ports: word_count  input  addrSize  number of instructions to load; sampled on accepted start.
REQ-006 SHALL have ports: s_valid  input  1, s_ready  output  1, s_data  input  byteWidth; byte stream in, transfer on s_valid&&s_ready.
REQ-007 SHALL have ports: imem_we  output  1, imem_addr  output  addrSize, imem_wdata  output  instructionSize; instruction-memory write port.
REQ-008 SHALL have ports: cpu_rst  output  1  processor reset hold.
REQ-009 SHALL have ports: busy  output  1, done  output  1, chk_err  output  1  status.

Function
REQ-010 SHALL implement FSM states IDLE, RECV, WRITE, CHECK, DONE.
REQ-011 IDLE/DONE + start SHALL latch word_count, clear address and byte counters, clear done and chk_err, go to RECV; word_count==0 SHALL go directly to CHECK if compiled in, else DONE.
REQ-012 start in RECV, WRITE or CHECK SHALL be ignored.
REQ-013 RECV SHALL assert s_ready; each transfer shifts s_data into the word, first byte into bits [23:16] (MSB first), BYTES_PER_WORD = instructionSize/byteWidth = 3 bytes per word.
REQ-014 On acceptance of byte 3, SHALL enter WRITE next cycle; WRITE SHALL deassert s_ready, pulse imem_we exactly one cycle with imem_addr = word index, imem_wdata = assembled word.
REQ-015 After WRITE: address SHALL increment; if written words == latched count go to CHECK (compiled in) or DONE, else back to RECV.
REQ-016 Write latency: imem_we SHALL assert the cycle after the third byte's transfer edge.
REQ-017 s_valid low SHALL stall the FSM with no state change; s_data SHALL be ignored when s_ready is low.
REQ-018 imem_addr SHALL be addrSize wide, wrapping 2^addrSize-1 -> 0 (reachable only for word_count==0 treated as 0 words, so no wrap within one load).
REQ-019 busy SHALL be 1 in RECV, WRITE, CHECK; done SHALL be 1 only in DONE, sticky until next accepted start or rst.
REQ-020 cpu_rst SHALL be 1 in all states except DONE.
REQ-021 imem_we, s_ready SHALL be 0 in IDLE, CHECK (except as REQ-025), DONE.

Reset
REQ-022 rst SHALL force IDLE, cpu_rst=1, busy=0, done=0, chk_err=0, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, counters 0.
REQ-023 rst mid-load SHALL abort; partial word discarded; no imem_we in the cycle following rst.

Configuration
REQ-024 Macro LOADER_CHECKSUM_EN SHALL compile the CHECK state and running XOR accumulator of all accepted bytes.
REQ-025 With it: CHECK asserts s_ready, accepts one checksum byte, sets chk_err = ((acc ^ byte) != 0), then DONE.
REQ-026 Without it: no CHECK state or accumulator; chk_err tied 0; last WRITE goes directly to DONE.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, INSTRUCTION_SIZE=24, BYTE_WIDTH=8, BYTES_PER_WORD.
REQ-028 One sub-module, loader_byte_packer (shift register + byte counter, word_valid output), SHALL be instantiated; FSM and address counter stay in program_loader.

Verification
REQ-029 word_count=2, bytes 12 34 56 AB CD EF, s_valid constant -> imem_we at addr0 data 0x123456, addr1 data 0xABCDEF; done=1, cpu_rst=0.
REQ-030 Same stream with s_valid deasserted 4 cycles between bytes 2 and 3 -> identical writes, no imem_we during stall.
REQ-031 word_count=0 -> no imem_we, done=1 within 2 cycles (checksum off).
REQ-032 rst asserted after byte 5 of REQ-029 stream -> IDLE, one write only (addr0), cpu_rst=1, done=0; new start reloads from addr0.
REQ-033 LOADER_CHECKSUM_EN, word_count=1, bytes 01 02 04 then 07 -> chk_err=0; checksum 06 -> chk_err=1; done=1 both.
REQ-034 start pulsed during RECV -> ignored, load completes with original count.
